change_event_logger: RTL

CHANGE_EVENT_LOGGER -- requirements
Module: change_event_logger

---
 rtl/change_event_logger.sv | 125 ++++++++++++
 1 files changed

// File: rtl/change_event_logger.sv
// Watches sig_in for value changes and queues {new, previous, timestamp} events
// in a small first-word-fall-through FIFO. Events that find the FIFO full are counted.
module change_event_logger #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    sig_in,
    input  logic                clear,
    input  logic                ev_ready,
    output logic                ev_valid,
    output logic [WIDTH-1:0]    ev_data,
    output logic [WIDTH-1:0]    ev_prev,
    output logic [TS_WIDTH-1:0] ev_time,
    output logic                overflow,
    output logic [7:0]          drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE  = 1;
    localparam logic [AW:0]         CNT_ONE  = 1;
    localparam logic [AW:0]         CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    state_t              next_state;
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev;
    logic                ev_form;

    logic [WIDTH-1:0]    mem_data [DEPTH];
    logic [WIDTH-1:0]    mem_prev [DEPTH];
    logic [TS_WIDTH-1:0] mem_time [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    logic full;
    logic pop;
    logic push;
    logic drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            ts    <= '0;
            prev  <= '0;
        end else begin
            state <= next_state;
            ts    <= ts + TS_ONE;
            // prev tracks the last sampled value even when the event itself is dropped
            prev  <= sig_in;
        end
    end

    always_comb begin
        next_state = state;
        ev_form    = 1'b0;
        case (state)
            INIT: next_state = RUN;
            RUN:  ev_form    = (sig_in != prev);
            default: next_state = INIT;
        endcase
    end

    assign full     = (count == CNT_FULL);
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // A pop on the same edge frees the slot the new event needs
    assign push     = ev_form && (!full || pop);
    assign drop     = ev_form && full && !pop;

    assign ev_data = mem_data[rd_ptr];
    assign ev_prev = mem_prev[rd_ptr];
    assign ev_time = mem_time[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_prev[i] <= '0;
                mem_time[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= sig_in;
                mem_prev[wr_ptr] <= prev;
                mem_time[wr_ptr] <= ts;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop on the clearing edge still counts, so clear yields overflow=1, drop_count=1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= drop;
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
